alu_ex: RTL and testbench
=========================

ALU_EX -- requirements
Module: alu_ex

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width (legal: 8..64, even).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1: an operation is presented.
REQ-006 Port in_ready, output, 1: the block can accept an operation this cycle.
REQ-007 Port op, input, 5: operation code from the shared ALUC set.
REQ-008 Port a, input, WIDTH: operand A, which is also the shift amount source.
REQ-009 Port b, input, WIDTH: operand B, which is also the shifted value.
REQ-010 Port out_valid, output, 1: res, zero, hi and lo are valid this cycle (one-cycle pulse).
REQ-011 Port res, output, WIDTH: result. Port zero, output, 1: res == 0.
REQ-012 Port hi, output, WIDTH; port lo, output, WIDTH: architectural HI/LO register contents.

Function
REQ-013 An operation SHALL be accepted on a rising edge where in_valid && in_ready; in_ready SHALL equal (state == IDLE) && !rst.
REQ-014 Single-cycle ops SHALL be AND, OR, XOR, NOR, ADD, SUB, SLT (signed), SLTU, SLL/SRL/SRA (amount a[SHW-1:0]), LUI ({b[WIDTH/2-1:0], zeros}), MFHI, MFLO, MTHI, MTLO.
REQ-015 Single-cycle ops SHALL use registered outputs: accepted at edge N gives out_valid=1 in cycle N+1 with in_ready remaining 1, so back-to-back issue is allowed.
REQ-016 ADD and SUB SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-017 MTHI/MTLO SHALL write a into HI/LO at the accepting edge, with res = a.
REQ-018 MULT/MULTU SHALL run as an iterative shift-add over WIDTH cycles; DIV/DIVU SHALL run as a restoring divide over WIDTH cycles.
REQ-019 For MULT/MULTU/DIV/DIVU, out_valid SHALL pulse in cycle N+WIDTH+1, where N is the accept edge.
REQ-020 Signed MULT/DIV SHALL operate on magnitudes, then sign-correct: quotient sign = sa^sb, remainder sign = sa.
REQ-021 Multiply SHALL set {HI,LO} = full 2*WIDTH product; divide SHALL set LO = quotient and HI = remainder; for both, res = LO.
REQ-022 Divide by zero SHALL complete in normal latency with LO = all-ones and HI = a.
REQ-023 The FSM SHALL have states IDLE, MUL, DIV, DONE: IDLE->MUL/DIV on accepting a multi-cycle op; MUL/DIV->DONE when the iteration counter reaches WIDTH-1; DONE->IDLE unconditionally, with the out_valid pulse in DONE.
REQ-024 in_valid SHALL be ignored in MUL, DIV and DONE states, with no queuing.
REQ-025 An undefined op SHALL produce out_valid next cycle with res = 0 and HI/LO unchanged.
REQ-026 HI/LO SHALL update only when a multi-cycle op completes, or on MTHI/MTLO.

Reset
REQ-027 While rst=1: state=IDLE, out_valid=0, res=0, zero=1, hi=0, lo=0, and the iteration counter = 0.
REQ-028 Reset asserted mid-operation SHALL abort it with no out_valid; in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-029 With macro ALU_EX_DIV_EN defined, DIV/DIVU and the DIV state SHALL be implemented per REQ-018..REQ-022.
REQ-030 With ALU_EX_DIV_EN undefined, DIV/DIVU SHALL behave as undefined ops (REQ-025) and no divider logic SHALL be synthesised.

Structure
REQ-031 The ALUC opcode constants and the FSM state encodings SHALL live in the shared Parameters package, alongside the existing ALUC codes.
REQ-032 The iterative divider SHALL be a sub-module alu_ex_div (start, operands, signed flag -> done, quotient, remainder), instantiated only under ALU_EX_DIV_EN.

Verification (WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF, b=1 -> next cycle res=0x80000000, zero=0; back-to-back SUB a=b=5 -> res=0, zero=1.
REQ-034 MULT a=-3, b=5 accepted at edge 0 -> out_valid at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFF1, in_ready=0 for cycles 1..32.
REQ-035 DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF, then rst pulse at cycle 10 -> no out_valid, HI=LO=0, then MFLO returns 0.
REQ-037 SRA a=4, b=0x80000000 -> res=0xF8000000; LUI b=0x1234 -> res=0x12340000.
REQ-038 Build without ALU_EX_DIV_EN, issue DIV a=9, b=3 -> next cycle out_valid=1, res=0, HI/LO unchanged.

Source files
------------

// File: rtl/alu_ex_pkg.sv
// Shared parameters for the execute-stage ALU: ALUC operation codes and
// the sequencer state encodings.
package alu_ex_pkg;

  typedef enum logic [4:0] {
    ALUC_AND   = 5'd0,
    ALUC_OR    = 5'd1,
    ALUC_XOR   = 5'd2,
    ALUC_NOR   = 5'd3,
    ALUC_ADD   = 5'd4,
    ALUC_SUB   = 5'd5,
    ALUC_SLT   = 5'd6,
    ALUC_SLTU  = 5'd7,
    ALUC_SLL   = 5'd8,
    ALUC_SRL   = 5'd9,
    ALUC_SRA   = 5'd10,
    ALUC_LUI   = 5'd11,
    ALUC_MFHI  = 5'd12,
    ALUC_MFLO  = 5'd13,
    ALUC_MTHI  = 5'd14,
    ALUC_MTLO  = 5'd15,
    ALUC_MULT  = 5'd16,
    ALUC_MULTU = 5'd17,
    ALUC_DIV   = 5'd18,
    ALUC_DIVU  = 5'd19
  } aluc_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_ex_div.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per
// cycle; results are sign-corrected and presented combinationally with done_o.
module alu_ex_div #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic             busy_q, busy_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] quot_n, rem_n;

  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign ge      = ~diff[WIDTH];
  assign rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_n  = {quot_q[WIDTH-2:0], ge};

  // Divide by zero bypasses the iteration result: all-ones quotient, dividend as remainder.
  assign done_o = busy_q && (cnt_q == SHW'(WIDTH-1));
  assign quot_o = dz_q ? '1 : (qneg_q ? -quot_n : quot_n);
  assign rem_o  = dz_q ? dvnd_q : (rneg_q ? -rem_n : rem_n);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    dvnd_d = dvnd_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quot_d = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      rem_d  = '0;
      dvsr_d = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
      dvnd_d = a_i;
      qneg_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_d = signed_i && a_i[WIDTH-1];
      dz_d   = (b_i == '0);
    end else if (busy_q) begin
      quot_d = quot_n;
      rem_d  = rem_n;
      cnt_d  = cnt_q + SHW'(1);
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      dvnd_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      dvnd_q <= dvnd_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

endmodule

// File: rtl/alu_ex.sv
// Execute-stage ALU with HI/LO registers and an iterative multiplier.
// Define ALU_EX_DIV_EN to build the iterative divider (DIV/DIVU).
module alu_ex
  import alu_ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_state_e         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic               ov_q, ov_d;

  logic               accept, mul_sgn, last;
  logic [WIDTH-1:0]   alu_r;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_n, prod_f;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign mul_sgn   = (op == ALUC_MULT);
  assign last      = (cnt_q == SHW'(WIDTH-1));
  assign out_valid = ov_q;
  assign res       = res_q;
  assign zero      = (res_q == '0);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Shift-add step: low half holds the remaining multiplier bits, high half accumulates.
  assign psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_n = {psum, prod_q[WIDTH-1:1]};
  assign prod_f = neg_q ? -prod_n : prod_n;

`ifdef ALU_EX_DIV_EN
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  assign div_start = accept && (op == ALUC_DIV || op == ALUC_DIVU);

  alu_ex_div #(.WIDTH(WIDTH), .SHW(SHW)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .a_i     (a),
    .b_i     (b),
    .signed_i(op == ALUC_DIV),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .rem_o   (div_rem)
  );
`endif

  always_comb begin
    alu_r = '0;
    case (op)
      ALUC_AND:  alu_r = a & b;
      ALUC_OR:   alu_r = a | b;
      ALUC_XOR:  alu_r = a ^ b;
      ALUC_NOR:  alu_r = ~(a | b);
      ALUC_ADD:  alu_r = a + b;
      ALUC_SUB:  alu_r = a - b;
      ALUC_SLT:  alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALUC_SLTU: alu_r = {{(WIDTH-1){1'b0}}, a < b};
      ALUC_SLL:  alu_r = b << a[SHW-1:0];
      ALUC_SRL:  alu_r = b >> a[SHW-1:0];
      ALUC_SRA:  alu_r = $signed(b) >>> a[SHW-1:0];
      ALUC_LUI:  alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALUC_MFHI: alu_r = hi_q;
      ALUC_MFLO: alu_r = lo_q;
      ALUC_MTHI, ALUC_MTLO: alu_r = a;
      default:   alu_r = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          case (op)
            ALUC_MULT, ALUC_MULTU: begin
              mcand_d = (mul_sgn && a[WIDTH-1]) ? -a : a;
              prod_d  = {{WIDTH{1'b0}}, ((mul_sgn && b[WIDTH-1]) ? -b : b)};
              neg_d   = mul_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              state_d = MUL;
            end
`ifdef ALU_EX_DIV_EN
            ALUC_DIV, ALUC_DIVU: state_d = DIV;
`endif
            default: begin
              res_d = alu_r;
              ov_d  = 1'b1;
              if (op == ALUC_MTHI) hi_d = a;
              if (op == ALUC_MTLO) lo_d = a;
            end
          endcase
        end
      end
      MUL: begin
        prod_d = prod_n;
        cnt_d  = cnt_q + SHW'(1);
        if (last) begin
          hi_d    = prod_f[2*WIDTH-1:WIDTH];
          lo_d    = prod_f[WIDTH-1:0];
          res_d   = prod_f[WIDTH-1:0];
          ov_d    = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
`ifdef ALU_EX_DIV_EN
      DIV: begin
        cnt_d = cnt_q + SHW'(1);
        if (div_done) begin
          hi_d    = div_rem;
          lo_d    = div_quot;
          res_d   = div_quot;
          ov_d    = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_ex.sv
// Scoreboard bench for alu_ex (WIDTH=32); DIV checks follow ALU_EX_DIV_EN.
module tb_alu_ex;
  import alu_ex_pkg::*;

  localparam int W = 32;

  logic         clk, rst, in_valid, in_ready, out_valid, zero;
  logic [4:0]   op;
  logic [W-1:0] a, b, res, hi, lo;

  alu_ex #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .res(res),
    .zero(zero), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] res, hi, lo;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_tests, n_fail, cyc;
  logic [W-1:0] m_hi, m_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference behaviour, written from the ALUC definitions.
  task automatic model(input logic [4:0] o, input logic [W-1:0] x, y,
                       output logic [W-1:0] r, output bit multi);
    logic [63:0] p;
    longint      q, rm;
    multi = 1'b0;
    r     = '0;
    case (o)
      ALUC_AND:  r = x & y;
      ALUC_OR:   r = x | y;
      ALUC_XOR:  r = x ^ y;
      ALUC_NOR:  r = ~(x | y);
      ALUC_ADD:  r = x + y;
      ALUC_SUB:  r = x - y;
      ALUC_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALUC_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      ALUC_SLL:  r = y << x[4:0];
      ALUC_SRL:  r = y >> x[4:0];
      ALUC_SRA:  r = $signed(y) >>> x[4:0];
      ALUC_LUI:  r = {y[15:0], 16'h0000};
      ALUC_MFHI: r = m_hi;
      ALUC_MFLO: r = m_lo;
      ALUC_MTHI: begin m_hi = x; r = x; end
      ALUC_MTLO: begin m_lo = x; r = x; end
      ALUC_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; multi = 1'b1;
      end
      ALUC_MULTU: begin
        p = {32'h0, x} * {32'h0, y};
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; multi = 1'b1;
      end
`ifdef ALU_EX_DIV_EN
      ALUC_DIV, ALUC_DIVU: begin
        if (y == '0) begin
          m_lo = '1; m_hi = x;
        end else if (o == ALUC_DIV) begin
          q  = longint'($signed(x)) / longint'($signed(y));
          rm = longint'($signed(x)) % longint'($signed(y));
          m_lo = q[31:0]; m_hi = rm[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
        r = m_lo; multi = 1'b1;
      end
`endif
      default: r = '0;
    endcase
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input logic [4:0] o, input logic [W-1:0] x, y, input bit track);
    exp_t        e;
    bit          multi;
    int unsigned n;
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("issue_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    model(o, x, y, e.res, multi);
    e.op  = o;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.due = cyc + 1 + (multi ? W : 0);
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    if (multi && track) begin
      op = ALUC_ADD;  // held request while busy must be dropped
      for (int k = 1; k <= W; k++) begin
        @(negedge clk);
        check("busy_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
        @(negedge clk); n++;
      end
      @(posedge clk); #1;
    end else begin
      in_valid = 1'b0;
      if (track) check("ready_after_single", 64'(in_ready), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("res op%0d", e.op),  64'(res),  64'(e.res));
        check($sformatf("zero op%0d", e.op), 64'(zero), 64'(e.res == '0));
        check($sformatf("hi op%0d", e.op),   64'(hi),   64'(e.hi));
        check($sformatf("lo op%0d", e.op),   64'(lo),   64'(e.lo));
        check($sformatf("latency op%0d", e.op), 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  ro;
    int unsigned n;
    n_tests = 0; n_fail = 0; cyc = 0;
    m_hi = '0; m_lo = '0;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res",       64'(res),       64'd0);
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_hi",        64'(hi),        64'd0);
    check("rst_lo",        64'(lo),        64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    issue(ALUC_ADD, 32'h7FFF_FFFF, 32'h1, 1);
    issue(ALUC_SUB, 32'd5, 32'd5, 1);
    issue(ALUC_SRA, 32'd4, 32'h8000_0000, 1);
    issue(ALUC_LUI, 32'h0, 32'h1234, 1);
    issue(ALUC_SLT, 32'hFFFF_FFFF, 32'd1, 1);
    issue(ALUC_SLTU, 32'hFFFF_FFFF, 32'd1, 1);
    issue(ALUC_SLL, 32'd31, 32'h3, 1);
    issue(ALUC_SRL, 32'd8, 32'hF000_00FF, 1);
    issue(ALUC_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 1);
    issue(ALUC_MTHI, 32'hDEAD_BEEF, 32'h0, 1);
    issue(ALUC_MTLO, 32'h1357_9BDF, 32'h0, 1);
    issue(ALUC_MFHI, 32'h0, 32'h0, 1);
    issue(5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    issue(ALUC_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    issue(ALUC_MFLO, 32'h0, 32'h0, 1);
    issue(ALUC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(ALUC_MULT, 32'h8000_0000, 32'h8000_0000, 1);
`ifdef ALU_EX_DIV_EN
    issue(ALUC_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    issue(ALUC_DIVU, 32'd5, 32'd0, 1);
    issue(ALUC_DIV, 32'd100, 32'hFFFF_FFF9, 1);
    issue(ALUC_DIVU, 32'hFFFF_FFF0, 32'd7, 1);
`else
    issue(ALUC_DIV, 32'd9, 32'd3, 1);
    issue(ALUC_DIVU, 32'd9, 32'd3, 1);
`endif

    for (int i = 0; i < 12; i++) begin
      ro = 5'($urandom_range(0, 31));
      if (ro >= 5'd16 && ro <= 5'd19) ro = ALUC_XOR;
      issue(ro, $urandom, $urandom, 1);
    end

    // Reset during a multiply: no result, HI/LO cleared.
    issue(ALUC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_hi",        64'(hi),        64'd0);
    check("abort_lo",        64'(lo),        64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("abort_ready_after_rst", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    issue(ALUC_MFLO, 32'h0, 32'h0, 1);
    issue(ALUC_MFHI, 32'h0, 32'h0, 1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
